nibble_pair_serializer: RTL and testbench

Sequential transmitter for the nibble-serial reduction path. It accepts one pair of 16-bit operands (A, B) through a valid/ready handshake. It then streams the four nibble pairs out least-significant first, one beat per transfer, each with a running unsigned partial sum. The downstream consumer therefore sees the same nibble pairs the ALU reduction op combines in parallel, but delivered serially with backpressure.

---
 rtl/nibble_pair_serializer.sv | 133 +++++++++++++
 tb/tb_nibble_pair_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_pair_serializer.sv
// Accepts one pair of 16-bit operands and streams their four nibble pairs,
// least-significant first, each beat carrying a running unsigned partial sum.
module nibble_pair_serializer #(
    parameter int PSUM_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       A,
    input  logic [15:0]       B,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_a_nib,
    output logic [3:0]        out_b_nib,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic [PSUM_W-1:0] out_psum,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         a_q, a_d;
    logic [15:0]         b_q, b_d;
    logic [1:0]          idx_q, idx_d;
    logic [PSUM_W-1:0]   acc_q, acc_d;

    function automatic logic [3:0] nib_sel(input logic [15:0] word, input logic [1:0] idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

    // Beat outputs decoded from the held operands; all data reads 0 while idle.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_a_nib = 4'd0;
        out_b_nib = 4'd0;
        out_idx   = 2'd0;
        out_last  = 1'b0;
        out_psum  = {PSUM_W{1'b0}};
        case (state_q)
            ST_SEND: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                busy      = 1'b1;
                out_a_nib = nib_sel(a_q, idx_q);
                out_b_nib = nib_sel(b_q, idx_q);
                out_idx   = idx_q;
                out_last  = (idx_q == 2'd3);
                // Max 8*15 = 120, so PSUM_W >= 7 never overflows.
                out_psum  = acc_q + PSUM_W'(nib_sel(a_q, idx_q)) + PSUM_W'(nib_sel(b_q, idx_q));
            end
            ST_IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    // Next-state logic: accept in IDLE, advance on beat transfer, flush wins over out_ready.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    state_d = ST_SEND;
                    a_d     = A;
                    b_d     = B;
                    idx_d   = 2'd0;
                    acc_d   = {PSUM_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    acc_d   = {PSUM_W{1'b0}};
                end else if (out_ready) begin
                    if (out_last) begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                        acc_d   = {PSUM_W{1'b0}};
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        acc_d   = out_psum;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                acc_d   = {PSUM_W{1'b0}};
            end
        endcase
    end

    // State and operand registers; reset drops any partial transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            idx_q   <= 2'd0;
            acc_q   <= {PSUM_W{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_nibble_pair_serializer.sv
// Self-checking bench: directed and randomized operand pairs compared against
// an arithmetic reference of the nibble stream, stalls, flush and reset.
module tb_nibble_pair_serializer;

    logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic        out_last, busy;
    logic [15:0] A, B;
    logic [3:0]  out_a_nib, out_b_nib;
    logic [1:0]  out_idx;
    logic [7:0]  out_psum;

    int checks = 0;
    int errors = 0;

    nibble_pair_serializer #(.PSUM_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a_nib(out_a_nib), .out_b_nib(out_b_nib), .out_idx(out_idx),
        .out_last(out_last), .out_psum(out_psum), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [21:0] IDLE_VEC = {1'b0, 1'b1, 1'b0, 19'd0};

    function automatic int nib(input logic [15:0] w, input int i);
        return (int'(w) >> (4 * i)) & 15;
    endfunction

    // Reference partial sum: total of all A and B nibbles with index <= i.
    function automatic int psum_upto(input logic [15:0] a, input logic [15:0] b, input int i);
        int s = 0;
        for (int j = 0; j <= i; j++) s += nib(a, j) + nib(b, j);
        return s;
    endfunction

    function automatic logic [21:0] beat_vec(input logic [15:0] a, input logic [15:0] b, input int i);
        logic [3:0] an, bn;
        logic [1:0] ix;
        logic [7:0] ps;
        an = 4'(nib(a, i));
        bn = 4'(nib(b, i));
        ix = 2'(i);
        ps = 8'(psum_upto(a, b, i));
        return {1'b1, 1'b0, 1'b1, an, bn, ix, (i == 3), ps};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {out_valid, in_ready, busy, out_a_nib, out_b_nib, out_idx, out_last, out_psum};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair from IDLE and follow its four beats to completion.
    task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input bit rand_stall,
                            input int stall_beat, input int stall_n, input bit keep_valid,
                            input string name);
        int cycles = 0;
        int stalls = 0;
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            errors++;
            $display("FAIL %s_accept: got %h expected %h", name, obs_vec(), IDLE_VEC);
        end
        step();
        if (!keep_valid) in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit done = 1'b0;
            int guard = 0;
            int here = 0;
            while (!done && guard < 64) begin
                bit rdy;
                if (rand_stall) rdy = ($urandom_range(0, 3) != 0);
                else rdy = !(i == stall_beat && here < stall_n);
                out_ready = rdy;
                checks++;
                if (obs_vec() !== beat_vec(a, b, i)) begin
                    errors++;
                    $display("FAIL %s_beat%0d: got %h expected %h", name, i, obs_vec(), beat_vec(a, b, i));
                end
                step();
                cycles++;
                guard++;
                if (rdy) done = 1'b1;
                else begin
                    stalls++;
                    here++;
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: beat %0d got no transfer expected within 64 cycles", name, i);
            end
        end
        out_ready = 1'b1;
        checks++;
        if (obs_vec() !== IDLE_VEC || cycles != 4 + stalls) begin
            errors++;
            $display("FAIL %s_done: got %h after %0d cycles expected %h after %0d cycles",
                     name, obs_vec(), cycles + 1, IDLE_VEC, stalls + 5);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; A = 16'd0; B = 16'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), IDLE_VEC);
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs_vec(), IDLE_VEC);
        end
    endtask

    task automatic test_directed();
        run_pair(16'h1234, 16'h5678, 1'b0, 0, 0, 1'b0, "basic");
        run_pair(16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 1'b0, "max_sum");
        run_pair(16'h00A0, 16'h0B00, 1'b0, 1, 3, 1'b0, "stall3");
    endtask

    task automatic test_flush();
        A = 16'h1234; B = 16'h5678; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec() !== beat_vec(16'h1234, 16'h5678, i)) begin
                errors++;
                $display("FAIL flush_pre%0d: got %h expected %h", i, obs_vec(), beat_vec(16'h1234, 16'h5678, i));
            end
            step();
        end
        flush = 1'b1;
        checks++;
        if (obs_vec() !== beat_vec(16'h1234, 16'h5678, 2)) begin
            errors++;
            $display("FAIL flush_beat2: got %h expected %h", obs_vec(), beat_vec(16'h1234, 16'h5678, 2));
        end
        step();
        flush = 1'b0;
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            errors++;
            $display("FAIL flush_idle: got %h expected %h", obs_vec(), IDLE_VEC);
        end
        // flush in IDLE must block a simultaneous in_valid
        A = 16'hBEEF; B = 16'hCAFE; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            errors++;
            $display("FAIL flush_blocks_accept: got %h expected %h", obs_vec(), IDLE_VEC);
        end
        run_pair(16'h0001, 16'h0001, 1'b0, 0, 0, 1'b0, "after_flush");
    endtask

    task automatic test_reset_mid();
        A = 16'h9876; B = 16'h5432; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (obs_vec() !== beat_vec(16'h9876, 16'h5432, 1)) begin
            errors++;
            $display("FAIL rstmid_beat1: got %h expected %h", obs_vec(), beat_vec(16'h9876, 16'h5432, 1));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            errors++;
            $display("FAIL rstmid_async: got %h expected %h", obs_vec(), IDLE_VEC);
        end
        step();
        rst = 1'b0;
        run_pair(16'h0F0F, 16'h3C3C, 1'b0, 0, 0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 8; p++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            run_pair(a, b, (p % 2) == 1, 0, 0, 1'b1, "b2b");
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            errors++;
            $display("FAIL b2b_end: got %h expected %h", obs_vec(), IDLE_VEC);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            run_pair(a, b, 1'b1, 0, 0, 1'b0, "rand");
            step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
